mby_msh_wr_dp_mc: RTL and testbench

//   Multi-channel mesh write datapath. Accepts credit-flow-controlled write requests on NUM_CH

---
 rtl/mby_msh_wr_dp_mc_if.sv | 28 ++
 rtl/mby_msh_wr_dp_mc.sv | 129 ++++++++++++
 tb/tb_mby_msh_wr_dp_mc.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mby_msh_wr_dp_mc_if.sv
// Bundle for the write-request side and bank write port of the multi-channel mesh write datapath.
interface mby_msh_wr_dp_mc_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 512,
  parameter int unsigned ADDR_W = 14
);
  localparam int unsigned CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]        i_wr_vld;
  logic [NUM_CH*ADDR_W-1:0] i_wr_addr;
  logic [NUM_CH*DATA_W-1:0] i_wr_data;
  logic [NUM_CH-1:0]        o_wr_crd;
  logic                     i_mem_stall;
  logic                     o_mem_wr_en;
  logic [ADDR_W-1:0]        o_mem_wr_addr;
  logic [DATA_W-1:0]        o_mem_wr_data;
  logic [CH_W-1:0]          o_mem_wr_ch;

  modport master (
    output i_wr_vld, i_wr_addr, i_wr_data, i_mem_stall,
    input  o_wr_crd, o_mem_wr_en, o_mem_wr_addr, o_mem_wr_data, o_mem_wr_ch
  );

  modport slave (
    input  i_wr_vld, i_wr_addr, i_wr_data, i_mem_stall,
    output o_wr_crd, o_mem_wr_en, o_mem_wr_addr, o_mem_wr_data, o_mem_wr_ch
  );
endinterface

// File: rtl/mby_msh_wr_dp_mc.sv
// Multi-channel mesh write datapath: per-channel credit FIFOs merged by a round-robin
// arbiter onto one bank write port through a stallable pipeline.
module mby_msh_wr_dp_mc #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DATA_W      = 512,
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic              mclk,
  input  logic              mrst,
  mby_msh_wr_dp_mc_if.slave bus,
  output logic [NUM_CH-1:0] o_ovfl_err,
  output logic              o_idle
);
  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = ADDR_W + DATA_W;
  localparam int unsigned LAST  = PIPE_STAGES - 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [ENT_W-1:0]       r_mem  [NUM_CH][FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wptr [NUM_CH];
  logic [PTR_W-1:0]       r_rptr [NUM_CH];
  logic [CNT_W-1:0]       r_cnt  [NUM_CH];
  logic [NUM_CH-1:0]      r_ovfl;
  logic [NUM_CH-1:0]      r_crd;
  logic [CH_W-1:0]        r_rr;
  logic [PIPE_STAGES-1:0] r_vld;
  logic [CH_W-1:0]        r_ch   [PIPE_STAGES];
  logic [ENT_W-1:0]       r_ent  [PIPE_STAGES];

  logic [NUM_CH-1:0] w_req;
  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_pop;
  logic [NUM_CH-1:0] w_push;
  logic              w_stall;
  logic              w_gnt_vld;
  logic [CH_W-1:0]   w_gnt_ch;
  logic [ENT_W-1:0]  w_gnt_ent;

  assign w_stall = bus.i_mem_stall;

  function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int unsigned off);
    return CH_W'((32'(base) + off) % NUM_CH);
  endfunction

  // A push is accepted unless the FIFO is full and not draining on the same edge.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_req[c]  = (r_cnt[c] != '0);
    assign w_full[c] = (r_cnt[c] == FULL_CNT);
    assign w_pop[c]  = w_gnt_vld && (w_gnt_ch == CH_W'(c));
    assign w_push[c] = bus.i_wr_vld[c] && (!w_full[c] || w_pop[c]);
  end

  // Round-robin search from r_rr; scanning downwards lets the nearest requester win.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_ch  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (!w_stall && w_req[rr_idx(r_rr, unsigned'(k))]) begin
        w_gnt_vld = 1'b1;
        w_gnt_ch  = rr_idx(r_rr, unsigned'(k));
      end
    end
  end

  assign w_gnt_ent = r_mem[w_gnt_ch][r_rptr[w_gnt_ch]];

  always_ff @(posedge mclk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_push[c]) begin
        r_mem[c][r_wptr[c]] <= {bus.i_wr_addr[c*ADDR_W +: ADDR_W], bus.i_wr_data[c*DATA_W +: DATA_W]};
      end
    end
  end

  always_ff @(posedge mclk or posedge mrst) begin
    if (mrst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
        r_cnt[c]  <= '0;
      end
      r_ovfl <= '0;
      r_crd  <= '0;
      r_rr   <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_push[c]) r_wptr[c] <= r_wptr[c] + 1'b1;
        if (w_pop[c])  r_rptr[c] <= r_rptr[c] + 1'b1;
        if (w_push[c] && !w_pop[c])      r_cnt[c] <= r_cnt[c] + 1'b1;
        else if (!w_push[c] && w_pop[c]) r_cnt[c] <= r_cnt[c] - 1'b1;
        if (bus.i_wr_vld[c] && !w_push[c]) r_ovfl[c] <= 1'b1;
      end
      r_crd <= w_pop;
      if (w_gnt_vld) r_rr <= rr_idx(w_gnt_ch, 1);
    end
  end

  // Stall freezes every stage so the last one re-presents its write when the bank frees up.
  always_ff @(posedge mclk or posedge mrst) begin
    if (mrst) begin
      r_vld <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) begin
        r_ch[i]  <= '0;
        r_ent[i] <= '0;
      end
    end else if (!w_stall) begin
      r_vld[0] <= w_gnt_vld;
      r_ch[0]  <= w_gnt_ch;
      r_ent[0] <= w_gnt_ent;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_ch[i]  <= r_ch[i-1];
        r_ent[i] <= r_ent[i-1];
      end
    end
  end

  assign bus.o_wr_crd      = r_crd;
  assign bus.o_mem_wr_en   = r_vld[LAST] && !w_stall;
  assign bus.o_mem_wr_addr = r_ent[LAST][ENT_W-1 -: ADDR_W];
  assign bus.o_mem_wr_data = r_ent[LAST][DATA_W-1:0];
  assign bus.o_mem_wr_ch   = r_ch[LAST];
  assign o_ovfl_err        = r_ovfl;
  assign o_idle            = (w_req == '0) && (r_vld == '0);
endmodule

// File: tb/tb_mby_msh_wr_dp_mc.sv
// Self-checking bench for mby_msh_wr_dp_mc: directed latency/arbitration/stall/overflow/reset
// scenarios plus random credit-obeying traffic against per-channel queues.
module tb_mby_msh_wr_dp_mc;
  localparam int unsigned NUM_CH      = 4;
  localparam int unsigned DATA_W      = 512;
  localparam int unsigned ADDR_W      = 14;
  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int unsigned PIPE_STAGES = 2;
  localparam int unsigned CH_W        = $clog2(NUM_CH);
  localparam int unsigned ENT_W       = ADDR_W + DATA_W;

  logic              mclk = 1'b0;
  logic              mrst;
  logic [NUM_CH-1:0] ovfl;
  logic              idle;
  int                errors = 0;
  int                checks = 0;
  logic [ENT_W-1:0]  q [NUM_CH][$];

  mby_msh_wr_dp_mc_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mby_msh_wr_dp_mc #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .FIFO_DEPTH(FIFO_DEPTH), .PIPE_STAGES(PIPE_STAGES)
  ) dut (
    .mclk(mclk), .mrst(mrst), .bus(bus), .o_ovfl_err(ovfl), .o_idle(idle)
  );

  always #5 mclk = ~mclk;

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic clr_inputs();
    bus.i_wr_vld  = '0;
    bus.i_wr_addr = '0;
    bus.i_wr_data = '0;
  endtask

  task automatic put(input int c, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.i_wr_vld[c] = 1'b1;
    bus.i_wr_addr[c*ADDR_W +: ADDR_W] = a;
    bus.i_wr_data[c*DATA_W +: DATA_W] = d;
  endtask

  function automatic logic [DATA_W-1:0] make_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < int'(DATA_W / 32); i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic test_reset();
    checks++; if (bus.o_mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", bus.o_mem_wr_en); end
    checks++; if (bus.o_wr_crd !== 4'b0) begin errors++; $display("FAIL reset_crd: got %b want 0000", bus.o_wr_crd); end
    checks++; if (bus.o_mem_wr_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.o_mem_wr_addr); end
    checks++; if (bus.o_mem_wr_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.o_mem_wr_data); end
    checks++; if (bus.o_mem_wr_ch !== '0) begin errors++; $display("FAIL reset_ch: got %0d want 0", bus.o_mem_wr_ch); end
    checks++; if (ovfl !== 4'b0) begin errors++; $display("FAIL reset_ovfl: got %b want 0000", ovfl); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", idle); end
  endtask

  // All channels push together; grants go 0..3 from a reset pointer and again after it wraps.
  task automatic test_rr();
    logic exp_en;
    logic [3:0] exp_crd;
    logic [ADDR_W-1:0] exp_addr;
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < int'(NUM_CH); c++) put(c, ADDR_W'(32'h40 + 16*b + c), make_data());
      tick();
      clr_inputs();
      for (int k = 1; k <= 7; k++) begin
        exp_en  = (k >= 3 && k <= 6);
        exp_crd = (k >= 2 && k <= 5) ? 4'(1 << (k - 2)) : 4'b0;
        exp_addr = ADDR_W'(32'h40 + 16*b + (k - 3));
        checks++; if (bus.o_mem_wr_en !== exp_en) begin errors++; $display("FAIL rr_en b%0d k%0d: got %b want %b", b, k, bus.o_mem_wr_en, exp_en); end
        checks++; if (bus.o_wr_crd !== exp_crd) begin errors++; $display("FAIL rr_crd b%0d k%0d: got %b want %b", b, k, bus.o_wr_crd, exp_crd); end
        if (exp_en) begin
          checks++; if (bus.o_mem_wr_ch !== CH_W'(k - 3)) begin errors++; $display("FAIL rr_ch b%0d k%0d: got %0d want %0d", b, k, bus.o_mem_wr_ch, k - 3); end
          checks++; if (bus.o_mem_wr_addr !== exp_addr) begin errors++; $display("FAIL rr_addr b%0d k%0d: got %h want %h", b, k, bus.o_mem_wr_addr, exp_addr); end
        end
        tick();
      end
    end
  endtask

  task automatic test_single();
    logic [DATA_W-1:0] pat;
    logic exp_en;
    logic [3:0] exp_crd;
    pat = {64{8'hA5}};
    put(2, 14'h12A, pat);
    tick();
    clr_inputs();
    for (int k = 1; k <= 5; k++) begin
      exp_en  = (k == 3);
      exp_crd = (k == 2) ? 4'b0100 : 4'b0000;
      checks++; if (bus.o_mem_wr_en !== exp_en) begin errors++; $display("FAIL single_en k%0d: got %b want %b", k, bus.o_mem_wr_en, exp_en); end
      checks++; if (bus.o_wr_crd !== exp_crd) begin errors++; $display("FAIL single_crd k%0d: got %b want %b", k, bus.o_wr_crd, exp_crd); end
      if (exp_en) begin
        checks++; if (bus.o_mem_wr_ch !== 2'd2) begin errors++; $display("FAIL single_ch: got %0d want 2", bus.o_mem_wr_ch); end
        checks++; if (bus.o_mem_wr_addr !== 14'h12A) begin errors++; $display("FAIL single_addr: got %h want 12a", bus.o_mem_wr_addr); end
        checks++; if (bus.o_mem_wr_data !== pat) begin errors++; $display("FAIL single_data: got %h want %h", bus.o_mem_wr_data, pat); end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [DATA_W-1:0] dq [4];
    logic exp_en;
    logic [3:0] exp_crd;
    bus.i_mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dq[i] = make_data();
      clr_inputs();
      put(0, ADDR_W'(32'h200 + i), dq[i]);
      tick();
      checks++; if (bus.o_mem_wr_en !== 1'b0 || bus.o_wr_crd !== 4'b0) begin errors++; $display("FAIL stall_push_quiet i%0d: got en=%b crd=%b want 0", i, bus.o_mem_wr_en, bus.o_wr_crd); end
    end
    clr_inputs();
    for (int k = 0; k < 6; k++) begin
      checks++; if (bus.o_mem_wr_en !== 1'b0 || bus.o_wr_crd !== 4'b0 || idle !== 1'b0) begin errors++; $display("FAIL stall_hold k%0d: got en=%b crd=%b idle=%b want 0,0000,0", k, bus.o_mem_wr_en, bus.o_wr_crd, idle); end
      tick();
    end
    bus.i_mem_stall = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      exp_en  = (k >= 2 && k <= 5);
      exp_crd = (k >= 1 && k <= 4) ? 4'b0001 : 4'b0000;
      checks++; if (bus.o_mem_wr_en !== exp_en) begin errors++; $display("FAIL stall_drain_en k%0d: got %b want %b", k, bus.o_mem_wr_en, exp_en); end
      checks++; if (bus.o_wr_crd !== exp_crd) begin errors++; $display("FAIL stall_drain_crd k%0d: got %b want %b", k, bus.o_wr_crd, exp_crd); end
      if (exp_en) begin
        checks++; if (bus.o_mem_wr_addr !== ADDR_W'(32'h200 + k - 2) || bus.o_mem_wr_data !== dq[k-2]) begin errors++; $display("FAIL stall_drain_word k%0d: got addr %h want %h", k, bus.o_mem_wr_addr, ADDR_W'(32'h200 + k - 2)); end
      end
      tick();
    end
  endtask

  task automatic test_ovfl();
    logic [DATA_W-1:0] dq [5];
    logic [3:0] exp_ov;
    int n;
    bus.i_mem_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dq[i] = make_data();
      clr_inputs();
      put(1, ADDR_W'(32'h300 + i), dq[i]);
      tick();
      exp_ov = (i == 4) ? 4'b0010 : 4'b0000;
      checks++; if (ovfl !== exp_ov) begin errors++; $display("FAIL ovfl_set i%0d: got %b want %b", i, ovfl, exp_ov); end
    end
    clr_inputs();
    repeat (3) tick();
    bus.i_mem_stall = 1'b0;
    #1;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.o_mem_wr_en === 1'b1) begin
        checks++;
        if (n >= 4) begin errors++; $display("FAIL ovfl_extra: got write addr %h want none", bus.o_mem_wr_addr); end
        else if (bus.o_mem_wr_ch !== 2'd1 || bus.o_mem_wr_addr !== ADDR_W'(32'h300 + n) || bus.o_mem_wr_data !== dq[n]) begin
          errors++; $display("FAIL ovfl_word n%0d: got ch %0d addr %h want ch 1 addr %h", n, bus.o_mem_wr_ch, bus.o_mem_wr_addr, ADDR_W'(32'h300 + n));
        end
        n++;
      end
      tick();
    end
    checks++; if (n != 4) begin errors++; $display("FAIL ovfl_count: got %0d writes want 4", n); end
    checks++; if (ovfl !== 4'b0010) begin errors++; $display("FAIL ovfl_sticky: got %b want 0010", ovfl); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL ovfl_idle: got %b want 1", idle); end
  endtask

  task automatic test_mid_reset();
    logic [DATA_W-1:0] d;
    int n;
    bus.i_mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clr_inputs();
      put(3, ADDR_W'(32'h3A0 + i), make_data());
      tick();
    end
    clr_inputs();
    bus.i_mem_stall = 1'b0;
    #1;
    tick();
    tick();
    checks++; if (bus.o_mem_wr_en !== 1'b1 || bus.o_mem_wr_ch !== 2'd3) begin errors++; $display("FAIL mrst_pre: got en=%b ch=%0d want 1,3", bus.o_mem_wr_en, bus.o_mem_wr_ch); end
    #2 mrst = 1'b1;
    #1;
    test_reset();
    tick();
    tick();
    checks++; if (bus.o_mem_wr_en !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL mrst_hold: got en=%b idle=%b want 0,1", bus.o_mem_wr_en, idle); end
    mrst = 1'b0;
    d = make_data();
    put(3, 14'h155, d);
    tick();
    clr_inputs();
    n = 0;
    for (int k = 1; k <= 8; k++) begin
      if (bus.o_mem_wr_en === 1'b1) begin
        n++;
        checks++;
        if (k != 3 || bus.o_mem_wr_ch !== 2'd3 || bus.o_mem_wr_addr !== 14'h155 || bus.o_mem_wr_data !== d) begin
          errors++; $display("FAIL mrst_after k%0d: got ch %0d addr %h want k3 ch 3 addr 155", k, bus.o_mem_wr_ch, bus.o_mem_wr_addr);
        end
      end
      tick();
    end
    checks++; if (n != 1) begin errors++; $display("FAIL mrst_count: got %0d writes want 1", n); end
  endtask

  // Credit-obeying senders with random stall; every bank write must be the head of its channel queue.
  task automatic test_random();
    int crd [NUM_CH];
    logic [ENT_W-1:0] e;
    logic [ENT_W-1:0] got;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    int ch;
    for (int c = 0; c < int'(NUM_CH); c++) crd[c] = int'(FIFO_DEPTH);
    for (int cyc = 0; cyc < 600; cyc++) begin
      bus.i_mem_stall = (cyc < 500) && ($urandom_range(3) == 0);
      #1;
      for (int c = 0; c < int'(NUM_CH); c++) if (bus.o_wr_crd[c] === 1'b1) crd[c]++;
      if (bus.i_mem_stall) begin
        checks++; if (bus.o_mem_wr_en !== 1'b0) begin errors++; $display("FAIL rand_stall_en cyc%0d: got %b want 0", cyc, bus.o_mem_wr_en); end
      end
      if (bus.o_mem_wr_en === 1'b1) begin
        ch  = int'(bus.o_mem_wr_ch);
        got = {bus.o_mem_wr_addr, bus.o_mem_wr_data};
        checks++;
        if (q[ch].size() == 0) begin
          errors++; $display("FAIL rand_unexpected cyc%0d: got write ch %0d addr %h want none", cyc, ch, bus.o_mem_wr_addr);
        end else begin
          e = q[ch].pop_front();
          if (got !== e) begin errors++; $display("FAIL rand_order cyc%0d ch%0d: got addr %h want addr %h", cyc, ch, got[ENT_W-1 -: ADDR_W], e[ENT_W-1 -: ADDR_W]); end
        end
      end
      clr_inputs();
      if (cyc < 500) begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
          if (crd[c] > 0 && $urandom_range(1) == 1) begin
            a = ADDR_W'($urandom);
            d = make_data();
            put(c, a, d);
            crd[c]--;
            q[c].push_back({a, d});
          end
        end
      end
      tick();
    end
    for (int c = 0; c < int'(NUM_CH); c++) begin
      checks++; if (q[c].size() != 0) begin errors++; $display("FAIL rand_loss ch%0d: got %0d undelivered want 0", c, q[c].size()); end
      checks++; if (crd[c] != int'(FIFO_DEPTH)) begin errors++; $display("FAIL rand_credits ch%0d: got %0d want %0d", c, crd[c], FIFO_DEPTH); end
    end
    checks++; if (ovfl !== 4'b0) begin errors++; $display("FAIL rand_ovfl: got %b want 0000", ovfl); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rand_idle: got %b want 1", idle); end
  endtask

  initial begin
    mrst = 1'b1;
    bus.i_mem_stall = 1'b0;
    clr_inputs();
    tick();
    tick();
    test_reset();
    mrst = 1'b0;
    tick();
    test_rr();
    test_single();
    test_stall();
    test_ovfl();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
